// File: rtl/sdr_tuning_controller_if.sv
// Byte stream from the UART receiver into the tuning controller.
// The master drives a validated byte with a one-cycle strobe.
// The slave samples the byte on the clock edge where the strobe is high.
interface sdr_tuning_controller_if;
    logic       rx_valid;
    logic [7:0] rx_byte;

    modport master (output rx_valid, output rx_byte);
    modport slave  (input  rx_valid, input  rx_byte);
endinterface

// File: rtl/sdr_tuning_controller.sv
// SDR tuning controller.
// Decodes ASCII command bytes and maintains the following state:
//   - per-channel NCO phase increments,
//   - the shared CIC gain,
//   - the active-channel selection.
// Commands are single-byte presets/steps/gain, 'c'<digit> channel select,
// and 'x' followed by PHASE_WIDTH/4 hex digits for a full phase load.
// Every output comes straight from a register.
module sdr_tuning_controller #(
    parameter int PHASE_WIDTH  = 64,
    parameter int NUM_CHANNELS = 2,
    parameter int GAIN_WIDTH   = 8,
    parameter int GAIN_MAX     = 3,
    parameter logic [PHASE_WIDTH-1:0] PRESET_A = 64'h4CF41F212D77318,
    parameter logic [PHASE_WIDTH-1:0] PRESET_B = 64'h1AA60F8B8911654,
    parameter logic [PHASE_WIDTH-1:0] STEP_9K  = 64'h71B375868D170,
    parameter logic [PHASE_WIDTH-1:0] STEP_1K  = 64'hCA22980BA57E,
    parameter logic [PHASE_WIDTH-1:0] STEP_100 = 64'h1436A8CDF6F3,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    sdr_tuning_controller_if.slave               rx_if,
    output logic [NUM_CHANNELS*PHASE_WIDTH-1:0]  phase_increment_o,
    output logic [NUM_CHANNELS-1:0]              phase_update_o,
    output logic [GAIN_WIDTH-1:0]                cic_gain_o,
    output logic [CH_W-1:0]                      active_channel_o,
    output logic                                 busy_o,
    output logic                                 cmd_error_o
);

    localparam int DIGITS = PHASE_WIDTH / 4;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [GAIN_WIDTH-1:0] GAIN_MAX_C = GAIN_WIDTH'(GAIN_MAX);
    localparam logic [CNT_W-1:0]      LAST_DIGIT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHAN = 2'd1,
        ST_HEX  = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [NUM_CHANNELS*PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [NUM_CHANNELS-1:0]           update_q, update_d;
    logic [GAIN_WIDTH-1:0]             gain_q, gain_d;
    logic [CH_W-1:0]                   chan_q, chan_d;
    logic [PHASE_WIDTH-1:0]            sr_q, sr_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              busy_q, busy_d;
    logic                              err_q, err_d;

    logic [PHASE_WIDTH-1:0]            cur_phase_s;
    logic                              wr_en_s;
    logic [PHASE_WIDTH-1:0]            wr_val_s;
    logic [4:0]                        hex_s;
    logic [PHASE_WIDTH-1:0]            sr_shift_s;
    logic [GAIN_WIDTH-1:0]             digit_s;

    // Returns {valid, nibble} for an ASCII hex character (either case).
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, b[3:0]};
        end else if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46)) begin
            r = {1'b1, 4'(b[3:0] + 4'd9)};
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

    // Returns 1 for an ASCII decimal digit.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // Select the increment of the active channel.
    always_comb begin
        cur_phase_s = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (chan_q == CH_W'(k)) begin
                cur_phase_s = phase_q[k*PHASE_WIDTH +: PHASE_WIDTH];
            end else begin
                cur_phase_s = cur_phase_s;
            end
        end
    end

    // Command decoder: next state, tuning state and one-cycle pulses.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        update_d   = '0;
        gain_d     = gain_q;
        chan_d     = chan_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        wr_en_s    = 1'b0;
        wr_val_s   = cur_phase_s;
        hex_s      = hex_decode(rx_if.rx_byte);
        sr_shift_s = {sr_q[PHASE_WIDTH-5:0], hex_s[3:0]};
        digit_s    = GAIN_WIDTH'(rx_if.rx_byte[3:0]);

        case (state_q)
            ST_IDLE: begin
                if (rx_if.rx_valid) begin
                    case (rx_if.rx_byte) inside
                        8'h61: begin wr_en_s = 1'b1; wr_val_s = PRESET_A; end              // 'a'
                        8'h62: begin wr_en_s = 1'b1; wr_val_s = PRESET_B; end              // 'b'
                        8'h6D: begin wr_en_s = 1'b1; wr_val_s = cur_phase_s + STEP_9K;  end // 'm'
                        8'h6E: begin wr_en_s = 1'b1; wr_val_s = cur_phase_s - STEP_9K;  end // 'n'
                        8'h72: begin wr_en_s = 1'b1; wr_val_s = cur_phase_s + STEP_1K;  end // 'r'
                        8'h71: begin wr_en_s = 1'b1; wr_val_s = cur_phase_s - STEP_1K;  end // 'q'
                        8'h70: begin wr_en_s = 1'b1; wr_val_s = cur_phase_s + STEP_100; end // 'p'
                        8'h6F: begin wr_en_s = 1'b1; wr_val_s = cur_phase_s - STEP_100; end // 'o'
                        [8'h30:8'h39]: begin
                            gain_d = (digit_s > GAIN_MAX_C) ? GAIN_MAX_C : digit_s;
                        end
                        8'h2B: begin                                                        // '+'
                            if (gain_q < GAIN_MAX_C) gain_d = gain_q + GAIN_WIDTH'(1);
                            else                     gain_d = GAIN_MAX_C;
                        end
                        8'h2D: begin                                                        // '-'
                            if (gain_q != '0) gain_d = gain_q - GAIN_WIDTH'(1);
                            else              gain_d = '0;
                        end
                        8'h63: state_d = ST_CHAN;                                           // 'c'
                        8'h78: begin                                                        // 'x'
                            state_d = ST_HEX;
                            sr_d    = '0;
                            cnt_d   = '0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHAN: begin
                if (rx_if.rx_valid) begin
                    state_d = ST_IDLE;
                    if (is_digit(rx_if.rx_byte) && (int'(rx_if.rx_byte[3:0]) < NUM_CHANNELS)) begin
                        chan_d = CH_W'(rx_if.rx_byte[3:0]);
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_CHAN;
                end
            end
            ST_HEX: begin
                if (rx_if.rx_valid) begin
                    if (hex_s[4]) begin
                        if (cnt_q == LAST_DIGIT) begin
                            // Last digit: commit the assembled increment.
                            wr_en_s  = 1'b1;
                            wr_val_s = sr_shift_s;
                            sr_d     = '0;
                            cnt_d    = '0;
                            state_d  = ST_IDLE;
                        end else begin
                            sr_d  = sr_shift_s;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        // Abort: the partial value is discarded, not committed.
                        err_d   = 1'b1;
                        sr_d    = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HEX;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sr_d    = '0;
                cnt_d   = '0;
            end
        endcase

        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (wr_en_s && (chan_q == CH_W'(k))) begin
                phase_d[k*PHASE_WIDTH +: PHASE_WIDTH] = wr_val_s;
                update_d[k] = 1'b1;
            end else begin
                update_d[k] = 1'b0;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            update_q <= '0;
            gain_q   <= '0;
            chan_q   <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            update_q <= update_d;
            gain_q   <= gain_d;
            chan_q   <= chan_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign phase_increment_o = phase_q;
    assign phase_update_o    = update_q;
    assign cic_gain_o        = gain_q;
    assign active_channel_o  = chan_q;
    assign busy_o            = busy_q;
    assign cmd_error_o       = err_q;

endmodule

// File: tb/tb_sdr_tuning_controller.sv
// Scoreboard bench for sdr_tuning_controller (2 channels, 64-bit increments).
// The driver feeds bytes into a command-level reference model and queues
// the expected outputs for each cycle. The monitor pops and compares them
// one cycle later.
module tb_sdr_tuning_controller;

    localparam logic [63:0] PA   = 64'h04CF41F212D77318;
    localparam logic [63:0] PB   = 64'h01AA60F8B8911654;
    localparam logic [63:0] S9K  = 64'h00071B375868D170;
    localparam logic [63:0] S1K  = 64'h0000CA22980BA57E;
    localparam logic [63:0] S100 = 64'h00001436A8CDF6F3;

    logic         clk;
    logic         rst;
    logic [127:0] ph_o;
    logic [1:0]   upd_o;
    logic [7:0]   gain_o;
    logic [0:0]   ch_o;
    logic         busy_o;
    logic         err_o;

    sdr_tuning_controller_if rx_if ();

    sdr_tuning_controller dut (
        .clk               (clk),
        .rst               (rst),
        .rx_if             (rx_if),
        .phase_increment_o (ph_o),
        .phase_update_o    (upd_o),
        .cic_gain_o        (gain_o),
        .active_channel_o  (ch_o),
        .busy_o            (busy_o),
        .cmd_error_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] ph0;
        logic [63:0] ph1;
        logic [1:0]  upd;
        logic [7:0]  gain;
        logic        ch;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state: command-level view.
    logic [63:0] m_ph [2];
    int          m_gain, m_ch, m_cnt;
    logic [63:0] m_acc;
    int          m_mode; // 0 = awaiting command, 1 = awaiting channel digit, 2 = collecting hex

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b - "0");
        if (b >= "a" && b <= "f") return int'(b - "a") + 10;
        if (b >= "A" && b <= "F") return int'(b - "A") + 10;
        return -1;
    endfunction

    task automatic model(input bit r, input bit v, input logic [7:0] b);
        exp_t        e;
        logic [1:0]  upd;
        bit          err;
        int          d;
        upd = 2'b00;
        err = 1'b0;
        if (r) begin
            m_ph[0] = 64'd0; m_ph[1] = 64'd0;
            m_gain = 0; m_ch = 0; m_mode = 0; m_cnt = 0; m_acc = 64'd0;
        end else if (v) begin
            if (m_mode == 0) begin
                if (b >= "0" && b <= "9") begin
                    d = int'(b - "0");
                    m_gain = (d > 3) ? 3 : d;
                end else begin
                    case (b)
                        "a": begin m_ph[m_ch] = PA;                upd[m_ch] = 1'b1; end
                        "b": begin m_ph[m_ch] = PB;                upd[m_ch] = 1'b1; end
                        "m": begin m_ph[m_ch] = m_ph[m_ch] + S9K;  upd[m_ch] = 1'b1; end
                        "n": begin m_ph[m_ch] = m_ph[m_ch] - S9K;  upd[m_ch] = 1'b1; end
                        "r": begin m_ph[m_ch] = m_ph[m_ch] + S1K;  upd[m_ch] = 1'b1; end
                        "q": begin m_ph[m_ch] = m_ph[m_ch] - S1K;  upd[m_ch] = 1'b1; end
                        "p": begin m_ph[m_ch] = m_ph[m_ch] + S100; upd[m_ch] = 1'b1; end
                        "o": begin m_ph[m_ch] = m_ph[m_ch] - S100; upd[m_ch] = 1'b1; end
                        "+": m_gain = (m_gain < 3) ? m_gain + 1 : 3;
                        "-": m_gain = (m_gain > 0) ? m_gain - 1 : 0;
                        "c": m_mode = 1;
                        "x": begin m_mode = 2; m_cnt = 0; m_acc = 64'd0; end
                        default: err = 1'b1;
                    endcase
                end
            end else if (m_mode == 1) begin
                if (b >= "0" && b <= "9" && int'(b - "0") < 2) m_ch = int'(b - "0");
                else err = 1'b1;
                m_mode = 0;
            end else begin
                d = hexval(b);
                if (d < 0) begin
                    err = 1'b1;
                    m_mode = 0;
                end else begin
                    m_acc = m_acc * 64'd16 + 64'(d);
                    m_cnt++;
                    if (m_cnt == 16) begin
                        m_ph[m_ch] = m_acc;
                        upd[m_ch] = 1'b1;
                        m_mode = 0;
                    end
                end
            end
        end
        e.ph0  = m_ph[0];
        e.ph1  = m_ph[1];
        e.upd  = upd;
        e.gain = 8'(m_gain);
        e.ch   = (m_ch != 0);
        e.busy = (m_mode != 0);
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic drive(input bit r, input bit v, input logic [7:0] b);
        @(negedge clk);
        rst            = r;
        rx_if.rx_valid = v;
        rx_if.rx_byte  = b;
        model(r, v, b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) drive(1'b0, 1'b1, s[i]);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'($urandom));
    endtask

    // Monitor: compare DUT outputs against the queued expectation every cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("phase_ch0", ph_o[63:0],   e.ph0);
            chk("phase_ch1", ph_o[127:64], e.ph1);
            chk("phase_update", 64'(upd_o), 64'(e.upd));
            chk("cic_gain", 64'(gain_o), 64'(e.gain));
            chk("active_channel", 64'(ch_o), 64'(e.ch));
            chk("busy", 64'(busy_o), 64'(e.busy));
            chk("cmd_error", 64'(err_o), 64'(e.err));
        end
    end

    initial begin
        logic [7:0] b;
        string      alpha;
        string      hexs;
        rst = 1'b1;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_byte  = 8'h00;
        alpha = "abmnqrpo0123456789+-cxzZ*dAF";
        hexs  = "0123456789abcdefABCDEF";

        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, "a");
        idle();
        #1 chk("reset_ph0", ph_o[63:0], 64'd0);

        // Preset and step on channel 0.
        send_str("a"); idle();
        #1 chk("preset_a_lit", ph_o[63:0], 64'h04CF41F212D77318);
        send_str("m"); idle();
        #1 chk("step_9k_lit", ph_o[63:0], 64'h04CF41F212D77318 + 64'h00071B375868D170);

        // Wrap-around below zero.
        drive(1'b1, 1'b0, 8'h00);
        send_str("o"); idle();
        #1 chk("wrap_lit", ph_o[63:0], 64'hFFFFEBC95732090D);

        // Channel select and full hex load.
        send_str("c1");
        send_str("x1dc38c076704516d"); idle();
        #1 chk("hex_load_lit", ph_o[127:64], 64'h1DC38C076704516D);

        // Gain clamp and saturation, then errors.
        send_str("7"); idle();
        #1 chk("gain_clamp_lit", 64'(gain_o), 64'd3);
        send_str("+0-");
        send_str("z");
        send_str("c5");
        send_str("x12g");
        idle();

        // Reset mid-HEX: later digits are IDLE commands.
        send_str("x12345678");
        drive(1'b1, 1'b1, "9");
        send_str("a5b9c0de");
        idle();

        // Randomized traffic with gaps, hex bursts and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 19))
                0, 1, 2: idle();
                3: begin
                    drive(1'b0, 1'b1, "x");
                    for (int j = 0; j < 16; j++) begin
                        b = hexs[$urandom_range(0, hexs.len() - 1)];
                        drive(1'b0, 1'b1, b);
                        if ($urandom_range(0, 7) == 0) idle();
                    end
                end
                4: drive(1'b0, 1'b1, 8'($urandom));
                5: if ($urandom_range(0, 9) == 0) drive(1'b1, 1'($urandom), 8'($urandom));
                   else drive(1'b0, 1'b1, 8'h1B);
                default: drive(1'b0, 1'b1, alpha[$urandom_range(0, alpha.len() - 1)]);
            endcase
        end

        idle();
        idle();
        repeat (3) @(posedge clk);
        #2 chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
